// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared constants for the GRF hazard scoreboard: forward codes, Tuse/Tnew
// encodings and scoreboard slot indexing.
package grf_hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_MFHI = 2'd1;

    localparam int unsigned NSLOT  = 3;
    localparam int unsigned SLOT_E = 0;
    localparam int unsigned SLOT_M = 1;
    localparam int unsigned SLOT_W = 2;

    // Slot index 0/1/2 (E/M/W) maps onto forward codes 1/2/3.
    function automatic logic [1:0] slot_fwd_code(input int unsigned idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/grf_hazard_scoreboard_if.sv
// D-stage hazard interface: pipeline drives the D-stage operand info,
// the scoreboard returns stall, forward selects and the stall counter.
interface grf_hazard_scoreboard_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2,
    parameter int unsigned CW = 32
);
    logic [AW-1:0] D_Rs;
    logic [AW-1:0] D_Rt;
    logic [TW-1:0] D_TuseRs;
    logic [TW-1:0] D_TuseRt;
    logic          D_WE;
    logic [AW-1:0] D_WA;
    logic [TW-1:0] D_TnewE;
    logic          D_IsMd;
    logic          MdBusy;
    logic          Flush;
    logic          Stall;
    logic [1:0]    FwdRs;
    logic [1:0]    FwdRt;
    logic [CW-1:0] StallCnt;

    modport master (
        output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_WE, D_WA, D_TnewE,
               D_IsMd, MdBusy, Flush,
        input  Stall, FwdRs, FwdRt, StallCnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_WE, D_WA, D_TnewE,
               D_IsMd, MdBusy, Flush,
        output Stall, FwdRs, FwdRt, StallCnt
    );
endinterface

// File: rtl/grf_src_resolve.sv
// Resolves one D-stage source operand against the E/M/W scoreboard slots.
module grf_src_resolve
    import grf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
) (
    input  logic [NSLOT-1:0]         slot_v_i,
    input  logic [NSLOT-1:0][AW-1:0] slot_wa_i,
    input  logic [NSLOT-1:0][TW-1:0] slot_tnew_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [TW-1:0]            tuse_i,
    output logic [1:0]               fwd_o,
    output logic                     hazard_o
);

    logic hit;

    // Nearest matching slot (E, then M, then W) decides forward/hazard.
    always_comb begin
        fwd_o    = FWD_GRF;
        hazard_o = 1'b0;
        hit      = 1'b0;
        if (tuse_i != TW'(TUSE_NONE)) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (!hit && slot_v_i[i] && (slot_wa_i[i] == addr_i)) begin
                    hit = 1'b1;
                    if (slot_tnew_i[i] == '0) begin
                        fwd_o = slot_fwd_code(i);
                    end else if (slot_tnew_i[i] > tuse_i) begin
                        hazard_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// D-stage hazard controller: 3-slot write scoreboard (E/M/W), stall and
// forward-select generation, and a stall-cycle counter.
module grf_hazard_scoreboard
    import grf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2,
    parameter int unsigned CW = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    grf_hazard_scoreboard_if.slave  hz
);

    logic [NSLOT-1:0]         sb_v_q, sb_v_d;
    logic [NSLOT-1:0][AW-1:0] sb_wa_q, sb_wa_d;
    logic [NSLOT-1:0][TW-1:0] sb_tnew_q, sb_tnew_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic       hazard_rs, hazard_rt, stall;
    logic [1:0] fwd_rs, fwd_rt;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    grf_src_resolve #(.AW(AW), .TW(TW)) u_rs (
        .slot_v_i    (sb_v_q),
        .slot_wa_i   (sb_wa_q),
        .slot_tnew_i (sb_tnew_q),
        .addr_i      (hz.D_Rs),
        .tuse_i      (hz.D_TuseRs),
        .fwd_o       (fwd_rs),
        .hazard_o    (hazard_rs)
    );

    grf_src_resolve #(.AW(AW), .TW(TW)) u_rt (
        .slot_v_i    (sb_v_q),
        .slot_wa_i   (sb_wa_q),
        .slot_tnew_i (sb_tnew_q),
        .addr_i      (hz.D_Rt),
        .tuse_i      (hz.D_TuseRt),
        .fwd_o       (fwd_rt),
        .hazard_o    (hazard_rt)
    );

    assign stall       = hazard_rs | hazard_rt | (hz.D_IsMd & hz.MdBusy);
    assign hz.Stall    = stall;
    assign hz.FwdRs    = fwd_rs;
    assign hz.FwdRt    = fwd_rt;
    assign hz.StallCnt = cnt_q;

    // Next scoreboard contents: flush clears, stall bubbles E, M/W always age.
    always_comb begin
        sb_v_d    = sb_v_q;
        sb_wa_d   = sb_wa_q;
        sb_tnew_d = sb_tnew_q;
        cnt_d     = cnt_q;
        if (hz.Flush) begin
            sb_v_d = '0;
        end else begin
            sb_v_d[SLOT_E]    = ~stall & hz.D_WE & (hz.D_WA != '0);
            sb_wa_d[SLOT_E]   = hz.D_WA;
            sb_tnew_d[SLOT_E] = hz.D_TnewE;
            sb_v_d[SLOT_M]    = sb_v_q[SLOT_E];
            sb_wa_d[SLOT_M]   = sb_wa_q[SLOT_E];
            sb_tnew_d[SLOT_M] = tnew_dec(sb_tnew_q[SLOT_E]);
            sb_v_d[SLOT_W]    = sb_v_q[SLOT_M];
            sb_wa_d[SLOT_W]   = sb_wa_q[SLOT_M];
            sb_tnew_d[SLOT_W] = tnew_dec(sb_tnew_q[SLOT_M]);
            if (stall) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Scoreboard and stall counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sb_v_q    <= '0;
            sb_wa_q   <= '0;
            sb_tnew_q <= '0;
            cnt_q     <= '0;
        end else begin
            sb_v_q    <= sb_v_d;
            sb_wa_q   <= sb_wa_d;
            sb_tnew_q <= sb_tnew_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Directed bench for grf_hazard_scoreboard with hand-computed expectations.
module tb_grf_hazard_scoreboard;
    import grf_hazard_scoreboard_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   exp_cnt;

    grf_hazard_scoreboard_if #(.AW(5), .TW(2), .CW(32)) hz ();

    grf_hazard_scoreboard #(.AW(5), .TW(2), .CW(32)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        hz.D_Rs     = '0;
        hz.D_Rt     = '0;
        hz.D_TuseRs = TUSE_NONE;
        hz.D_TuseRt = TUSE_NONE;
        hz.D_WE     = 1'b0;
        hz.D_WA     = '0;
        hz.D_TnewE  = '0;
        hz.D_IsMd   = 1'b0;
        hz.MdBusy   = 1'b0;
        hz.Flush    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [1:0] tnew);
        idle();
        hz.D_WE    = 1'b1;
        hz.D_WA    = wa;
        hz.D_TnewE = tnew;
    endtask

    task automatic rd(input logic [4:0] rs, input logic [1:0] tu_rs,
                      input logic [4:0] rt, input logic [1:0] tu_rt);
        idle();
        hz.D_Rs     = rs;
        hz.D_TuseRs = tu_rs;
        hz.D_Rt     = rt;
        hz.D_TuseRt = tu_rt;
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;
        idle();
        #1;
        check("rst_stall", 32'(hz.Stall), 0);
        check("rst_fwdrs", 32'(hz.FwdRs), 0);
        check("rst_fwdrt", 32'(hz.FwdRt), 0);
        check("rst_cnt", hz.StallCnt, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // addu $3 then beq $3
        wr(5'd3, TNEW_ALU);
        hz.D_Rs = 5'd1; hz.D_TuseRs = 2'd1;
        hz.D_Rt = 5'd2; hz.D_TuseRt = 2'd1;
        #1 check("alu_nostall", 32'(hz.Stall), 0);
        tick();
        rd(5'd3, 2'd0, 5'd0, 2'd0);
        #1 check("beq_stall", 32'(hz.Stall), 1);
        check("beq_fwd_during", 32'(hz.FwdRs), 0);
        tick(); exp_cnt++;
        #1 check("beq_release", 32'(hz.Stall), 0);
        check("beq_fwd_m", 32'(hz.FwdRs), 2);
        check("beq_cnt", hz.StallCnt, 32'(exp_cnt));
        tick(); idle(); tick(); tick(); tick();

        // lw $5 then addu using $5 at Tuse 1
        wr(5'd5, TNEW_LOAD);
        #1 check("lw_nostall", 32'(hz.Stall), 0);
        tick();
        rd(5'd5, 2'd1, 5'd0, TUSE_NONE);
        #1 check("lwuse_stall", 32'(hz.Stall), 1);
        tick(); exp_cnt++;
        #1 check("lwuse_release", 32'(hz.Stall), 0);
        check("lwuse_fwd", 32'(hz.FwdRs), 0);
        check("lwuse_cnt", hz.StallCnt, 32'(exp_cnt));
        idle(); tick(); tick(); tick();

        // write to $0 never creates a dependency
        wr(5'd0, TNEW_ALU);
        tick();
        rd(5'd0, 2'd0, 5'd0, 2'd0);
        #1 check("r0_stall", 32'(hz.Stall), 0);
        check("r0_fwdrs", 32'(hz.FwdRs), 0);
        check("r0_fwdrt", 32'(hz.FwdRt), 0);
        idle(); tick(); tick(); tick();

        // jal $31 then jr $31, followed through M and W
        wr(5'd31, TNEW_JAL);
        tick();
        rd(5'd31, 2'd0, 5'd31, 2'd0);
        #1 check("jr_stall", 32'(hz.Stall), 0);
        check("jr_fwdrs_e", 32'(hz.FwdRs), 1);
        check("jr_fwdrt_e", 32'(hz.FwdRt), 1);
        tick();
        #1 check("jr_fwdrs_m", 32'(hz.FwdRs), 2);
        tick();
        #1 check("jr_fwdrs_w", 32'(hz.FwdRs), 3);
        check("jr_stall_w", 32'(hz.Stall), 0);
        tick();
        #1 check("jr_retired", 32'(hz.FwdRs), 0);

        // nearest slot wins: E={7,1} shadows M={7,0}
        wr(5'd7, TNEW_JAL);
        tick();
        wr(5'd7, TNEW_ALU);
        tick();
        rd(5'd7, 2'd0, 5'd7, 2'd1);
        #1 check("near_stall", 32'(hz.Stall), 1);
        check("near_fwdrt", 32'(hz.FwdRt), 0);
        tick(); exp_cnt++;
        #1 check("near_release", 32'(hz.Stall), 0);
        check("near_fwdrs_m", 32'(hz.FwdRs), 2);
        check("near_fwdrt_m", 32'(hz.FwdRt), 2);
        check("near_cnt", hz.StallCnt, 32'(exp_cnt));
        idle(); tick(); tick(); tick();

        // MDU busy for 5 cycles
        idle();
        hz.D_IsMd = 1'b1;
        hz.MdBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("md_stall", 32'(hz.Stall), 1);
            tick(); exp_cnt++;
        end
        hz.MdBusy = 1'b0;
        #1 check("md_free", 32'(hz.Stall), 0);
        check("md_cnt", hz.StallCnt, 32'(exp_cnt));
        hz.D_IsMd = 1'b0;
        hz.MdBusy = 1'b1;
        #1 check("md_notmd", 32'(hz.Stall), 0);

        // flush during a stall clears slots and is not counted
        wr(5'd9, TNEW_LOAD);
        tick();
        rd(5'd9, 2'd0, 5'd0, TUSE_NONE);
        hz.Flush = 1'b1;
        #1 check("flush_stall", 32'(hz.Stall), 1);
        tick();
        hz.Flush = 1'b0;
        #1 check("flush_cleared", 32'(hz.Stall), 0);
        check("flush_fwd", 32'(hz.FwdRs), 0);
        check("flush_cnt", hz.StallCnt, 32'(exp_cnt));
        idle(); tick();

        // asynchronous reset with all slots valid
        wr(5'd10, TNEW_LOAD); tick();
        wr(5'd11, TNEW_LOAD); tick();
        wr(5'd12, TNEW_LOAD); tick();
        rd(5'd10, 2'd0, 5'd12, 2'd0);
        #1 check("full_fwdrs_w", 32'(hz.FwdRs), 3);
        check("full_stall", 32'(hz.Stall), 1);
        #1 rst_n = 1'b0;
        exp_cnt = 0;
        #1 check("arst_stall", 32'(hz.Stall), 0);
        check("arst_fwdrs", 32'(hz.FwdRs), 0);
        check("arst_fwdrt", 32'(hz.FwdRt), 0);
        check("arst_cnt", hz.StallCnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        wr(5'd13, TNEW_JAL);
        hz.D_Rs = 5'd12; hz.D_TuseRs = 2'd0;
        #1 check("post_rst_stall", 32'(hz.Stall), 0);
        tick();
        rd(5'd13, 2'd0, 5'd12, 2'd0);
        #1 check("post_rst_fwdrs", 32'(hz.FwdRs), 1);
        check("post_rst_fwdrt", 32'(hz.FwdRt), 0);
        check("post_rst_nostall", 32'(hz.Stall), 0);
        check("post_rst_cnt", hz.StallCnt, 32'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/grf_hazard_scoreboard.md
Name: grf_hazard_scoreboard

Overview:
- D-stage hazard controller for the 32x32 general register file in the 5-stage MIPS pipeline.
- Tracks in-flight register writes in E/M/W with a 3-slot shift scoreboard: destination address plus remaining Tnew.
- Compares the D-stage instruction's sources (with Tuse) against the scoreboard and produces Stall and D-stage forward selects.
- Handles multiply/divide busy stalls and exception flush, and counts stall cycles.

Parameters:
- AW, 5, register address width.
- TW, 2, Tnew/Tuse width. Tuse value 3 means "source not used".
- CW, 32, stall-cycle counter width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- D_Rs  in  AW  D-stage source 1 address.
- D_Rt  in  AW  D-stage source 2 address.
- D_TuseRs  in  TW  cycles until Rs is consumed (0=D, 1=E, 2=M, 3=unused).
- D_TuseRt  in  TW  same, for Rt.
- D_WE  in  1  D instruction writes the GRF.
- D_WA  in  AW  D destination address.
- D_TnewE  in  TW  Tnew the instruction will have on entering E (0..2).
- D_IsMd  in  1  D instruction uses the HI/LO/MDU.
- MdBusy  in  1  MDU busy or start issued this cycle.
- Flush  in  1  exception/eret flush of D/E/M.
- Stall  out  1  freeze PC and the F/D register; insert bubble into E.
- FwdRs  out  2  D-stage Rs source: 0=GRF, 1=E reg, 2=M reg, 3=W reg.
- FwdRt  out  2  same, for Rt.
- StallCnt  out  CW  cycles in which Stall was asserted.

Behaviour:
- Scoreboard slots E, M, W each hold {v, wa, tnew}.
  - wa==0 is stored as v=0; $0 never matches.
- Per-source resolution, combinational:
  - The nearest valid slot with matching wa wins, searched E, then M, then W.
  - No match: Fwd=0.
  - Match with tnew==0: Fwd = that slot's code.
  - Match with tnew>0 and tnew<=Tuse: Fwd=0, no stall (forwarded later by E/M forward muxes).
  - Match with tnew>Tuse: hazard.
  - Tuse==3: never hazard, Fwd=0.
- Stall = hazardRs | hazardRt | (D_IsMd & MdBusy). Stall is combinational, same cycle.
- Update at rising Clk, priority Reset > Flush > Stall > normal:
  - Normal: E <= {D_WE & (D_WA!=0), D_WA, D_TnewE}; M <= E with tnew-1 (saturating at 0); W <= M with tnew-1 (saturating at 0); old W retires.
  - Stall: E <= bubble (v=0); M and W shift as in normal. D inputs are held by the pipeline, not by this block.
  - Flush: all slots <= v=0. The excepting instruction in M never writes. Flush with simultaneous Stall behaves as Flush.
- StallCnt increments by 1 at each edge where Stall=1 and Flush=0. It wraps modulo 2^CW.
- Reset (Reset=0, asynchronous):
  - All slots v=0, StallCnt=0.
  - Hence Stall=0 and FwdRs=FwdRt=0 while D_IsMd=0.
  - Deassertion is synchronous to Clk (synchroniser outside the block).
- W-slot forwarding (code 3) covers the GRF write-then-read-in-same-cycle case. The GRF has no internal bypass.
- No X-propagation: unused slot fields are don't-care only when v=0.

Decomposition:
- Shared header constants:
  - FWD_GRF/FWD_E/FWD_M/FWD_W = 0..3.
  - TUSE_NONE=3.
  - Tnew per class: TNEW_ALU=1, TNEW_LOAD=2, TNEW_JAL=0, TNEW_MFHI=1.
- One natural sub-module: grf_src_resolve, one instance per source.
  - Inputs: slots, address, Tuse.
  - Outputs: fwd code, hazard.

Test Plan:
- Reset low mid-run with all slots valid -> Stall=0, Fwd=0, StallCnt=0 immediately; after release, first instruction enters E cleanly.
- addu $3 (Tnew 1) followed by beq $3 (TuseRs=0):
  - stalls 1 cycle, StallCnt=1;
  - next cycle the M slot has tnew 0, FwdRs=2.
- lw $5 (Tnew 2) followed by addu using $5 (Tuse 1):
  - cycle 1: Stall=1;
  - cycle 2: no stall, FwdRs=0 (M slot tnew 1 <= Tuse 1);
  - one stall total.
- Write to $0 (D_WE=1, D_WA=0) followed by a read of $0 with Tuse 0 -> no stall, Fwd=0.
- jal ($31, Tnew 0) followed by jr $31 -> FwdRs=1, no stall. Three instructions later the W slot matches: FwdRs=3.
- MdBusy=1 with D_IsMd=1 for 5 cycles -> Stall=1 for 5 cycles, StallCnt+=5. Flush during the stall -> slots cleared; that cycle is not counted.
